// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/LS memory task arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned LEN_W      = 3;

  localparam logic [1:0] LEN_BYTE   = 2'd0;
  localparam logic [1:0] LEN_HALF   = 2'd1;
  localparam logic [1:0] LEN_WORD   = 2'd2;
  localparam int unsigned LEN_SIGNED = 2;

  localparam logic [LEN_W-1:0] IF_LEN_DEF = 3'b010;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_LS = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_LS = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester (IF, LS) and memory-controller task signals seen by the arbiter.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W,
  parameter int unsigned DATA_W = ARB_DATA_W
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_data;

  logic              ls_req;
  logic              ls_write;
  logic [ADDR_W-1:0] ls_addr;
  logic [LEN_W-1:0]  ls_len;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_done;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_valid;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LEN_W-1:0]  mem_len;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_result;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, ls_req, ls_write, ls_addr, ls_len, ls_wdata,
           mem_ready, mem_result,
    output if_done, if_data, ls_done, ls_rdata,
           mem_valid, mem_write, mem_addr, mem_len, mem_wdata
  );

  // Requesters and memory controller side
  modport master (
    output if_req, if_addr, ls_req, ls_write, ls_addr, ls_len, ls_wdata,
           mem_ready, mem_result,
    input  if_done, if_data, ls_done, ls_rdata,
           mem_valid, mem_write, mem_addr, mem_len, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_picker2.sv
// Two-way round-robin pick: req[0]=IF, req[1]=LS; a tie goes to the one not granted last.
module mem_arbiter_rr_picker2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       any_c,
  output logic       pick_c
);

  always_comb begin
    any_c  = |req;
    pick_c = GRANT_IF;
    if (req[1] && (!req[0] || (last_grant == GRANT_IF))) pick_c = GRANT_LS;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-serial memory task port between instruction fetch and the load/store buffer.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned      ADDR_W = ARB_ADDR_W,
  parameter int unsigned      DATA_W = ARB_DATA_W,
  parameter logic [LEN_W-1:0] IF_LEN = IF_LEN_DEF
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         flush_in,
  mem_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              cancel_q, cancel_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LEN_W-1:0]  mem_len_q, mem_len_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_done_q, if_done_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic              ls_done_q, ls_done_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

  logic any_req_c, pick_c, grant_c, kill_c;

  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] r,
                                                    input logic [LEN_W-1:0]  len);
    logic sgn;
    sgn = len[LEN_SIGNED];
    case (len[1:0])
      LEN_BYTE: load_extend = {{(DATA_W-8){sgn & r[7]}}, r[7:0]};
      LEN_HALF: load_extend = {{(DATA_W-16){sgn & r[15]}}, r[15:0]};
      LEN_WORD: load_extend = r;
      default:  load_extend = r;
    endcase
  endfunction

  mem_arbiter_rr_picker2 u_picker (
    .req        ({bus.ls_req, bus.if_req}),
    .last_grant (last_grant_q),
    .any_c      (any_req_c),
    .pick_c     (pick_c)
  );

  assign grant_c = (state_q == ST_IDLE) && !flush_in && any_req_c;
  // A read is dropped if flushed earlier or in its own ready cycle; stores always commit.
  assign kill_c  = cancel_q | (flush_in & ~mem_write_q);

  always_ff @(posedge clk_in) begin
    if (rst_in)      state_q <= ST_IDLE;
    else if (rdy_in) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (grant_c) state_d = (pick_c == GRANT_LS) ? ST_BUSY_LS : ST_BUSY_IF;
      ST_BUSY_IF,
      ST_BUSY_LS: if (bus.mem_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    cancel_d     = cancel_q;
    mem_valid_d  = mem_valid_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_len_d    = mem_len_q;
    mem_wdata_d  = mem_wdata_q;
    if_done_d    = 1'b0;
    if_data_d    = if_data_q;
    ls_done_d    = 1'b0;
    ls_rdata_d   = ls_rdata_q;

    if (grant_c) begin
      mem_valid_d = 1'b1;
      if (pick_c == GRANT_LS) begin
        mem_write_d = bus.ls_write;
        mem_addr_d  = bus.ls_addr;
        mem_len_d   = bus.ls_len;
        mem_wdata_d = bus.ls_wdata;
      end else begin
        mem_write_d = 1'b0;
        mem_addr_d  = bus.if_addr;
        mem_len_d   = IF_LEN;
        mem_wdata_d = '0;
      end
    end else if (state_q != ST_IDLE) begin
      if (bus.mem_ready) begin
        mem_valid_d  = 1'b0;
        cancel_d     = 1'b0;
        last_grant_d = (state_q == ST_BUSY_LS) ? GRANT_LS : GRANT_IF;
        if (!kill_c) begin
          if (state_q == ST_BUSY_IF) begin
            if_done_d = 1'b1;
            if_data_d = bus.mem_result;
          end else begin
            ls_done_d = 1'b1;
            if (!mem_write_q) ls_rdata_d = load_extend(bus.mem_result, mem_len_q);
          end
        end
      end else if (flush_in && !mem_write_q) begin
        cancel_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last_grant_q <= GRANT_IF;
      cancel_q     <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_len_q    <= '0;
      mem_wdata_q  <= '0;
      if_done_q    <= 1'b0;
      if_data_q    <= '0;
      ls_done_q    <= 1'b0;
      ls_rdata_q   <= '0;
    end else if (rdy_in) begin
      last_grant_q <= last_grant_d;
      cancel_q     <= cancel_d;
      mem_valid_q  <= mem_valid_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_len_q    <= mem_len_d;
      mem_wdata_q  <= mem_wdata_d;
      if_done_q    <= if_done_d;
      if_data_q    <= if_data_d;
      ls_done_q    <= ls_done_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_len   = mem_len_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_data   = if_data_q;
  assign bus.ls_done   = ls_done_q;
  assign bus.ls_rdata  = ls_rdata_q;

endmodule
